// File: rtl/sha1_core_pipelined.sv
// SHA-1 compression engine: accepts pre-padded 512-bit blocks, chains multi-block
// messages through first/last flags, and evaluates ROUNDS_PER_CYCLE rounds per clock.
module sha1_core_pipelined #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit DIGEST_HOLD      = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_data,
  input  logic         block_first,
  input  logic         block_last,
  output logic         busy,
  output logic         digest_valid,
  output logic [159:0] digest
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rounds
    $error("sha1_core_pipelined: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ROUNDS = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [6:0] T_STEP = 7'(ROUNDS_PER_CYCLE);
  localparam logic [6:0] T_LAST = 7'(80 - ROUNDS_PER_CYCLE);

  // Index 0 is H0 / a; IV[0] = 67452301.
  localparam logic [4:0][31:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                     32'hEFCDAB89, 32'h67452301};

  // Handshake: a block transfers on a rising edge where block_valid && block_ready;
  // block_ready is asserted only in IDLE and DONE, and nothing is sampled otherwise.

  logic [2:0]        state_q, state_d;
  logic [4:0][31:0]  h_q, h_d;
  logic [4:0][31:0]  abcde_q, abcde_d;
  logic [15:0][31:0] w_q, w_d;
  logic [6:0]        t_q, t_d;
  logic              last_q, last_d;
  logic [159:0]      digest_q, digest_d;
  logic              dv_q, dv_d;

  logic [31:0]       ra, rb, rc, rd, re, rf, rk, rtmp, rnw;
  logic [15:0][31:0] rw;
  logic [4:0][31:0]  h_sum;
  logic              accept;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // R rounds unrolled; t_q is a multiple of R, so one K/f selection covers the cycle.
  always_comb begin
    ra   = abcde_q[0];
    rb   = abcde_q[1];
    rc   = abcde_q[2];
    rd   = abcde_q[3];
    re   = abcde_q[4];
    rw   = w_q;
    rf   = '0;
    rtmp = '0;
    rnw  = '0;
    if (t_q < 7'd20)      rk = 32'h5A827999;
    else if (t_q < 7'd40) rk = 32'h6ED9EBA1;
    else if (t_q < 7'd60) rk = 32'h8F1BBCDC;
    else                  rk = 32'hCA62C1D6;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      if (t_q < 7'd20)                     rf = (rb & rc) | (~rb & rd);
      else if (t_q >= 7'd40 && t_q < 7'd60) rf = (rb & rc) | (rb & rd) | (rc & rd);
      else                                 rf = rb ^ rc ^ rd;
      rtmp = rotl(ra, 5) + rf + re + rk + rw[0];
      re   = rd;
      rd   = rc;
      rc   = rotl(rb, 30);
      rb   = ra;
      ra   = rtmp;
      rnw  = rotl(rw[13] ^ rw[8] ^ rw[2] ^ rw[0], 1);
      rw   = {rnw, rw[15:1]};
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) h_sum[i] = h_q[i] + abcde_q[i];
  end

  assign block_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy         = ~block_ready;
  assign accept       = block_valid & block_ready;
  assign digest_valid = dv_q;
  assign digest       = digest_q;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    abcde_d  = abcde_q;
    w_d      = w_q;
    t_d      = t_q;
    last_d   = last_q;
    digest_d = digest_q;
    dv_d     = dv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && !DIGEST_HOLD) dv_d = 1'b0;
        if (accept) begin
          for (int i = 0; i < 16; i++) w_d[i] = block_data[511 - 32*i -: 32];
          last_d = block_last;
          if (block_first) begin
            h_d  = IV;
            dv_d = 1'b0;
          end
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        abcde_d = h_q;
        t_d     = '0;
        state_d = S_ROUNDS;
      end
      S_ROUNDS: begin
        abcde_d = {re, rd, rc, rb, ra};
        w_d     = rw;
        t_d     = t_q + T_STEP;
        if (t_q == T_LAST) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        h_d = h_sum;
        if (last_q) begin
          digest_d = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
          dv_d     = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      h_q      <= IV;
      abcde_q  <= '0;
      w_q      <= '0;
      t_q      <= '0;
      last_q   <= 1'b0;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      abcde_q  <= abcde_d;
      w_q      <= w_d;
      t_q      <= t_d;
      last_q   <= last_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
    end
  end

endmodule

// File: doc/sha1_core_pipelined.md
Name: sha1_core_pipelined

Overview:
- Parametrised SHA-1 compression engine; successor to the single-block fixed-rate core.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake and chains multi-block messages via first/last flags.
- Computes correct 32-bit rotations and the full 80-word message schedule.
- Configurable rounds-per-cycle unrolling trades area for latency.
- Sits between the message padder/packer upstream and the digest consumer downstream.

Parameters:
- ROUNDS_PER_CYCLE, 1, rounds evaluated per clock. Legal values: 1, 2, 4, 5 (must divide 20). Any other value is an elaboration error.
- DIGEST_HOLD, 1, 1: digest_valid stays high until the next first-block accept. 0: digest_valid is a single-cycle pulse.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- block_valid  in  1  upstream block available.
- block_ready  out  1  core can accept a block.
- block_data  in  512  padded block; word W0 = [511:480], W15 = [31:0], big-endian.
- block_first  in  1  block starts a new message (load IV).
- block_last  in  1  block ends the message (publish digest).
- busy  out  1  high in any state other than IDLE/DONE.
- digest_valid  out  1  digest is valid.
- digest  out  160  {H0,H1,H2,H3,H4}, H0 at [159:128].

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State goes to IDLE; H0..H4 load IV 67452301/EFCDAB89/98BADCFE/10325476/C3D2E1F0.
  - digest=0, digest_valid=0, busy=0.
  - block_ready is 1 in the first cycle after reset is released.
  - Reset mid-block aborts all work; no partial digest is ever published.
- States: IDLE, LOAD, ROUNDS, UPDATE, DONE.
- block_ready=1 only in IDLE and DONE; it is 0 in LOAD/ROUNDS/UPDATE. A block is accepted on the edge where block_valid & block_ready.
- On accept:
  - Latch W0..W15 and the first/last flags; go to LOAD.
  - If first=1, H is reloaded with IV on this edge.
  - If first=0, H is kept (chaining); after reset with no prior message, H=IV.
- LOAD (1 cycle): a..e ← H0..H4; t ← 0; go to ROUNDS.
- ROUNDS (80/R cycles, R = ROUNDS_PER_CYCLE):
  - Each cycle applies rounds t..t+R-1, then t += R.
  - Schedule is a 16-word sliding window: Wt = rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]) for t ≥ 16.
  - f/K per round:
    - t 0-19: f = (b&c)|(~b&d), K = 5A827999
    - t 20-39: f = b^c^d, K = 6ED9EBA1
    - t 40-59: f = maj(b,c,d), K = 8F1BBCDC
    - t 60-79: f = b^c^d, K = CA62C1D6
  - Round update: temp = rotl5(a)+f+e+K+Wt (mod 2^32); e←d; d←c; c←rotl30(b); b←a; a←temp.
  - R ≤ 5 and R divides 20, so a single cycle never straddles a K boundary.
  - After t reaches 80, go to UPDATE.
- UPDATE (1 cycle):
  - Hi ← Hi + {a..e}, each mod 2^32.
  - If last=1: digest ← new H, digest_valid ← 1, go to DONE. Else go to IDLE.
- Latency: digest_valid rises on handshake edge + (80/R + 2) edges, e.g. 82 edges for R=1 and 18 edges for R=5. Throughput is one block per 80/R + 3 cycles.
- DONE:
  - DIGEST_HOLD=1: digest_valid stays 1 until the next accept with first=1, then clears on that edge.
  - DIGEST_HOLD=0: digest_valid clears after 1 cycle.
  - A non-first block accepted in DONE chains from the published H.
  - digest is stable until the next UPDATE with last=1.
- first=1 and last=1 together: single-block message.
- block_data and flags are ignored while block_ready=0; the core holds no stale data.

Test Plan:
- "abc" single block (61626380, W1..W14=0, W15=00000018), first=last=1, R=1 → digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; digest_valid at handshake+82 edges.
- Empty message (80000000, remaining words 0), R=5 → da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709 at handshake+18 edges.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last) → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - block_ready must be 0 throughout processing.
  - block_valid held high during that time must not be consumed.
- Back-to-back messages: "abc", then the empty message with first=1 while in DONE → second digest is correct; digest_valid drops on the second accept (DIGEST_HOLD=1).
- reset_n pulsed low at round 40 of "abc", then "abc" resent → no digest_valid before the resend; final digest equals the correct "abc" digest.
- All legal R values (1, 2, 4, 5) on the "abc" vector → identical digests; latencies of 82/42/22/18 edges.
